// File: rtl/periodic_sync_generator_pkg.sv
// Shared definitions for the periodic sync generator and the blocks that
// consume its sync pulse (counter widths must agree on both sides).
package periodic_sync_generator_pkg;

    localparam int DEFAULT_PERIOD_WIDTH      = 32;
    localparam int DEFAULT_PULSE_WIDTH_WIDTH = 16;
    localparam int DEFAULT_COUNT_WIDTH       = 32;

    // Shortest period that still leaves room for one low cycle.
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } sync_state_t;

endpackage

// File: rtl/periodic_sync_generator_phase_counter.sv
// Phase counter with period/width shadow registers. Shadows load on start
// and on every wrap, so a period is never torn by input changes.
module sync_phase_counter
    import periodic_sync_generator_pkg::*;
#(
    parameter int PERIOD_WIDTH      = DEFAULT_PERIOD_WIDTH,
    parameter int PULSE_WIDTH_WIDTH = DEFAULT_PULSE_WIDTH_WIDTH
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         load,
    input  logic                         advance,
    input  logic                         halt,
    input  logic [PERIOD_WIDTH-1:0]      period,
    input  logic [PULSE_WIDTH_WIDTH-1:0] pulse_width,
    output logic [PERIOD_WIDTH-1:0]      phase,
    output logic                         sync_out,
    output logic                         wrap
);

    localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE   = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] p_reg;
    logic [PERIOD_WIDTH-1:0] w_reg;
    logic [PERIOD_WIDTH-1:0] p_clamp;
    logic [PERIOD_WIDTH-1:0] w_ext;
    logic [PERIOD_WIDTH-1:0] w_min1;
    logic [PERIOD_WIDTH-1:0] w_clamp;
    logic [PERIOD_WIDTH-1:0] phase_next;

    // Clamp incoming period/width: P >= 2, 1 <= W <= P-1.
    always_comb begin
        p_clamp    = (period < P_MIN) ? P_MIN : period;
        w_ext      = PERIOD_WIDTH'(pulse_width);
        w_min1     = (w_ext == '0) ? ONE : w_ext;
        w_clamp    = (w_min1 > (p_clamp - ONE)) ? (p_clamp - ONE) : w_min1;
        phase_next = phase + ONE;
    end

    assign wrap = (phase == (p_reg - ONE));

    // Phase advance, shadow reload at wrap, registered sync generation.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            phase    <= '0;
            sync_out <= 1'b0;
            p_reg    <= P_MIN;
            w_reg    <= ONE;
        end else if (halt) begin
            phase    <= '0;
            sync_out <= 1'b0;
        end else if (load || (advance && wrap)) begin
            // W is at least 1, so phase 0 is always high.
            p_reg    <= p_clamp;
            w_reg    <= w_clamp;
            phase    <= '0;
            sync_out <= 1'b1;
        end else if (advance) begin
            phase    <= phase_next;
            sync_out <= (phase_next < w_reg);
        end
    end

endmodule

// File: rtl/periodic_sync_generator.sv
// Programmable periodic sync-pulse source: bounded or free-running pulse
// trains with cycle-exact period and graceful stop at a period boundary.
//
// state    | meaning
// IDLE     | outputs quiet, waiting for start (without stop)
// RUN      | emitting pulses; ends on bounded count or stop at wrap
// STOPPING | finishing the current period, then back to IDLE
module periodic_sync_generator
    import periodic_sync_generator_pkg::*;
#(
    parameter int PERIOD_WIDTH      = DEFAULT_PERIOD_WIDTH,
    parameter int PULSE_WIDTH_WIDTH = DEFAULT_PULSE_WIDTH_WIDTH,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         start,
    input  logic                         stop,
    input  logic [PERIOD_WIDTH-1:0]      period,
    input  logic [PULSE_WIDTH_WIDTH-1:0] pulse_width,
    input  logic [COUNT_WIDTH-1:0]       pulse_count,
    output logic                         sync_out,
    output logic                         running,
    output logic                         done,
    output logic [COUNT_WIDTH-1:0]       pulses_emitted,
    output logic [PERIOD_WIDTH-1:0]      phase
);

    sync_state_t            state;
    logic [COUNT_WIDTH-1:0] n_reg;
    logic                   wrap;
    logic                   load;
    logic                   active;
    logic                   illegal;
    logic                   bounded_hit;
    logic                   ending;

    assign load        = (state == IDLE) && start && !stop;
    assign active      = (state == RUN) || (state == STOPPING);
    assign illegal     = !active && (state != IDLE);
    assign bounded_hit = (n_reg != '0) && (pulses_emitted == n_reg);
    // Stop seen exactly at the wrap cycle ends the train right there,
    // since the current period has just completed.
    assign ending      = active && wrap && ((state == STOPPING) || stop || bounded_hit);

    sync_phase_counter #(
        .PERIOD_WIDTH      (PERIOD_WIDTH),
        .PULSE_WIDTH_WIDTH (PULSE_WIDTH_WIDTH)
    ) u_phase (
        .clk         (clk),
        .aresetn     (aresetn),
        .load        (load),
        .advance     (active),
        .halt        (ending || illegal),
        .period      (period),
        .pulse_width (pulse_width),
        .phase       (phase),
        .sync_out    (sync_out),
        .wrap        (wrap)
    );

    // Train control FSM and saturating pulse counter.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state          <= IDLE;
            running        <= 1'b0;
            done           <= 1'b0;
            pulses_emitted <= '0;
            n_reg          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        n_reg          <= pulse_count;
                        pulses_emitted <= COUNT_WIDTH'(1);
                        running        <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    if (ending) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        if (wrap && (pulses_emitted != '1))
                            pulses_emitted <= pulses_emitted + COUNT_WIDTH'(1);
                        if ((state == RUN) && stop)
                            state <= STOPPING;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periodic_sync_generator.sv
// Directed self-checking bench for periodic_sync_generator.
module tb_periodic_sync_generator;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic [15:0] pulse_width;
    logic [31:0] pulse_count;
    logic        sync_out;
    logic        running;
    logic        done;
    logic [31:0] pulses_emitted;
    logic [31:0] phase;

    int vectors    = 0;
    int miscompares = 0;

    int cyc = 0;
    logic prev_sync = 1'b0;
    int rise_q[$];
    int done_q[$];
    int high_cnt = 0;

    periodic_sync_generator dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .start          (start),
        .stop           (stop),
        .period         (period),
        .pulse_width    (pulse_width),
        .pulse_count    (pulse_count),
        .sync_out       (sync_out),
        .running        (running),
        .done           (done),
        .pulses_emitted (pulses_emitted),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Waveform recorder: rising-edge and done cycles, total high time.
    always @(negedge clk) begin
        if (sync_out && !prev_sync) rise_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (sync_out) high_cnt++;
        prev_sync = sync_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_q.delete();
        done_q.delete();
        high_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({sync_out, running, done, pulses_emitted, phase} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state got sync=%b run=%b done=%b pe=%0d ph=%0d want all zero",
                     sync_out, running, done, pulses_emitted, phase);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_bounded();
        int t0;
        period = 10; pulse_width = 3; pulse_count = 4;
        clear_mon();
        pulse_start();
        t0 = cyc;
        vectors++;
        if ({sync_out, running, phase, pulses_emitted} !== {1'b1, 1'b1, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL start_latency got sync=%b run=%b ph=%0d pe=%0d want 1 1 0 1",
                     sync_out, running, phase, pulses_emitted);
        end
        wait_done(60);
        repeat (3) tick();
        vectors++;
        if (rise_q.size() !== 4) begin
            miscompares++;
            $display("FAIL bounded_pulses got %0d want 4", rise_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ((rise_q.size() > i ? rise_q[i] : -1) !== t0 + 10 * i) begin
                miscompares++;
                $display("FAIL bounded_rise%0d got %0d want %0d", i,
                         (rise_q.size() > i ? rise_q[i] - t0 : -1), 10 * i);
            end
        end
        vectors++;
        if (high_cnt !== 12) begin
            miscompares++;
            $display("FAIL bounded_high got %0d want 12", high_cnt);
        end
        vectors++;
        if ((done_q.size() == 1 ? done_q[0] - t0 + 1 : -1) !== 41) begin
            miscompares++;
            $display("FAIL bounded_done got %0d want 41 (count %0d)",
                     (done_q.size() > 0 ? done_q[0] - t0 + 1 : -1), done_q.size());
        end
        vectors++;
        if ({running, pulses_emitted} !== {1'b0, 32'd4}) begin
            miscompares++;
            $display("FAIL bounded_end got run=%b pe=%0d want 0 4", running, pulses_emitted);
        end
    endtask

    task automatic test_graceful_stop();
        int t_stop;
        period = 8; pulse_width = 2; pulse_count = 0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 100 && !(pulses_emitted == 5 && phase == 3); i++) tick();
        vectors++;
        if ({pulses_emitted, phase} !== {32'd5, 32'd3}) begin
            miscompares++;
            $display("FAIL stop_setup got pe=%0d ph=%0d want 5 3", pulses_emitted, phase);
        end
        t_stop = cyc;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(30);
        repeat (20) tick();
        vectors++;
        if ((done_q.size() == 1 ? done_q[0] - t_stop : -1) !== 5) begin
            miscompares++;
            $display("FAIL stop_done got %0d want 5 (count %0d)",
                     (done_q.size() > 0 ? done_q[0] - t_stop : -1), done_q.size());
        end
        vectors++;
        if ({rise_q.size(), high_cnt} !== {32'd5, 32'd10}) begin
            miscompares++;
            $display("FAIL stop_pulses got rises=%0d high=%0d want 5 10", rise_q.size(), high_cnt);
        end
        vectors++;
        if ({pulses_emitted, running, sync_out} !== {32'd5, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stop_end got pe=%0d run=%b sync=%b want 5 0 0", pulses_emitted, running, sync_out);
        end
    endtask

    task automatic test_reprogram();
        int gap[3];
        int want[3];
        want = '{10, 6, 6};
        period = 10; pulse_width = 3; pulse_count = 0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 20 && phase != 4; i++) tick();
        period = 6;
        for (int i = 0; i < 60 && rise_q.size() < 4; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(20);
        tick();
        for (int i = 0; i < 3; i++) begin
            gap[i] = (rise_q.size() > i + 1) ? rise_q[i + 1] - rise_q[i] : -1;
            vectors++;
            if (gap[i] !== want[i]) begin
                miscompares++;
                $display("FAIL reprog_gap%0d got %0d want %0d", i, gap[i], want[i]);
            end
        end
        vectors++;
        if (done_q.size() !== 1) begin
            miscompares++;
            $display("FAIL reprog_done got %0d done pulses want 1", done_q.size());
        end
    endtask

    task automatic test_clamp();
        int c_per[4];
        int c_pw[4];
        int c_p[4];
        int c_w[4];
        int t0;
        int gap;
        int dn;
        c_per = '{0, 1, 20, 20};
        c_pw  = '{3, 0, 0, 50};
        c_p   = '{2, 2, 20, 20};
        c_w   = '{1, 1, 1, 19};
        for (int k = 0; k < 4; k++) begin
            period = 32'(c_per[k]); pulse_width = 16'(c_pw[k]); pulse_count = 2;
            clear_mon();
            pulse_start();
            t0 = cyc;
            wait_done(60);
            repeat (2) tick();
            gap = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1;
            dn  = (done_q.size() == 1) ? done_q[0] - t0 : -1;
            vectors++;
            if (gap !== c_p[k]) begin
                miscompares++;
                $display("FAIL clamp%0d_period got %0d want %0d", k, gap, c_p[k]);
            end
            vectors++;
            if (high_cnt !== 2 * c_w[k]) begin
                miscompares++;
                $display("FAIL clamp%0d_width got %0d want %0d", k, high_cnt, 2 * c_w[k]);
            end
            vectors++;
            if (dn !== 2 * c_p[k]) begin
                miscompares++;
                $display("FAIL clamp%0d_done got %0d want %0d", k, dn, 2 * c_p[k]);
            end
        end
    endtask

    task automatic test_start_stop_both();
        logic [31:0] pe;
        pe = pulses_emitted;
        period = 5; pulse_width = 2; pulse_count = 0;
        clear_mon();
        start = 1'b1; stop = 1'b1;
        repeat (4) tick();
        start = 1'b0; stop = 1'b0;
        tick();
        vectors++;
        if ({running, sync_out, phase, pulses_emitted, 32'(rise_q.size())} !== {1'b0, 1'b0, 32'd0, pe, 32'd0}) begin
            miscompares++;
            $display("FAIL both_idle got run=%b sync=%b ph=%0d pe=%0d rises=%0d want 0 0 0 %0d 0",
                     running, sync_out, phase, pulses_emitted, rise_q.size(), pe);
        end
    endtask

    task automatic test_start_during_run();
        int t0;
        period = 5; pulse_width = 2; pulse_count = 2;
        clear_mon();
        pulse_start();
        t0 = cyc;
        repeat (2) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        wait_done(30);
        repeat (2) tick();
        vectors++;
        if ((done_q.size() == 1 ? done_q[0] - t0 : -1) !== 10) begin
            miscompares++;
            $display("FAIL rerun_done got %0d want 10", (done_q.size() > 0 ? done_q[0] - t0 : -1));
        end
        vectors++;
        if ({32'(rise_q.size()), pulses_emitted, running} !== {32'd2, 32'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL rerun_count got rises=%0d pe=%0d run=%b want 2 2 0",
                     rise_q.size(), pulses_emitted, running);
        end
    endtask

    task automatic test_back_to_back();
        period = 4; pulse_width = 1; pulse_count = 1;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_done got %b want 1", done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({sync_out, running, done, phase, pulses_emitted} !== {1'b1, 1'b1, 1'b0, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL b2b_restart got sync=%b run=%b done=%b ph=%0d pe=%0d want 1 1 0 0 1",
                     sync_out, running, done, phase, pulses_emitted);
        end
        repeat (8) tick();
    endtask

    task automatic test_reset_mid_train();
        period = 10; pulse_width = 3; pulse_count = 4;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 20 && phase != 5; i++) tick();
        aresetn = 1'b0;
        tick();
        vectors++;
        if ({sync_out, running, done, pulses_emitted, phase} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL midreset_state got sync=%b run=%b done=%b pe=%0d ph=%0d want all zero",
                     sync_out, running, done, pulses_emitted, phase);
        end
        aresetn = 1'b1;
        repeat (15) tick();
        vectors++;
        if ({32'(done_q.size()), running, phase} !== {32'd0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL midreset_idle got dones=%0d run=%b ph=%0d want 0 0 0",
                     done_q.size(), running, phase);
        end
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; stop = 1'b0;
        period = 0; pulse_width = 0; pulse_count = 0;
        test_reset();
        test_bounded();
        test_graceful_stop();
        test_reprogram();
        test_clamp();
        test_start_stop_both();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_train();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
